// File: rtl/sram_ctrl.sv
// Multi-cycle controller for the external asynchronous 32-bit SRAM, with programmable wait states.
// Define SRAM_BYTE_WRITE_EN to use byte enables for partial writes; otherwise they go through read-modify-write.
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        data_i,
  input  logic               tlb_hit_i,
  input  logic               sram_ce_i,
  output logic [31:0]        data_o,
  output logic               ack_o,
  output logic               stall_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  input  logic [31:0]        sram_dq_i,
  output logic [31:0]        sram_dq_o,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, WR_HOLD, DONE} state_e;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [3:0]          be_n_q, be_n_d;
  logic                accept;
  logic                last;
  logic [3:0]          sel_nx;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{addr_i[31:SRAM_AW+2], addr_i[1:0]};

  always_comb begin
    accept  = (state_q == IDLE) & req_i & tlb_hit_i & sram_ce_i & ~rst;
    last    = (cnt_q == '0);
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!we_i)               state_d = RD;
          else if (sel_i == '0)    state_d = DONE;
`ifndef SRAM_BYTE_WRITE_EN
          else if (sel_i != '1)    state_d = RMW_RD;
`endif
          else                     state_d = WR;
        end
      end
      RD:      if (last) state_d = DONE;
      RMW_RD:  if (last) state_d = WR;
      WR:      if (last) state_d = WR_HOLD;
      WR_HOLD: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = (state_d inside {RD, RMW_RD, WR}) ? WAIT_LAST : '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_comb begin
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept) begin
      addr_d  = addr_i[SRAM_AW+1:2];
      sel_d   = sel_i;
      wdata_d = data_i;
    end
    if (state_q == RD && last) begin
      rdata_d = sram_dq_i;
    end
`ifndef SRAM_BYTE_WRITE_EN
    // Merge happens on the last RMW read cycle so WR drives the full merged word from its first cycle.
    if (state_q == RMW_RD && last) begin
      for (int unsigned b = 0; b < 4; b++) begin
        wdata_d[8*b +: 8] = sel_q[b] ? wdata_q[8*b +: 8] : sram_dq_i[8*b +: 8];
      end
    end
`endif
  end

  // Strobes are derived from the next state so the pad outputs come straight from flops.
  always_comb begin
    sel_nx  = accept ? sel_i : sel_q;
    ce_n_d  = ~(state_d inside {RD, RMW_RD, WR, WR_HOLD});
    oe_n_d  = ~(state_d inside {RD, RMW_RD});
    we_n_d  = ~(state_d == WR);
    dq_oe_d = state_d inside {WR, WR_HOLD};
`ifdef SRAM_BYTE_WRITE_EN
    if (state_d inside {WR, WR_HOLD})      be_n_d = ~sel_nx;
    else if (state_d inside {RD, RMW_RD})  be_n_d = '0;
    else                                   be_n_d = '1;
`else
    be_n_d = ce_n_d ? '1 : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      be_n_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
      be_n_q  <= be_n_d;
    end
  end

  assign data_o      = rdata_q;
  assign ack_o       = (state_q == DONE);
  assign stall_o     = accept | ((state_q != IDLE) & (state_q != DONE));
  assign sram_addr_o = addr_q;
  assign sram_dq_o   = wdata_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_be_n   = be_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed cases plus random traffic against a word-array reference model.
module tb_sram_ctrl;

  localparam int unsigned W  = 2;
  localparam int unsigned AW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_i = 1'b0, we_i = 1'b0, tlb_hit_i = 1'b0, sram_ce_i = 1'b0;
  logic [31:0]   addr_i = '0, data_i = '0;
  logic [3:0]    sel_i = '0;
  logic [31:0]   data_o, sram_dq_i, sram_dq_o;
  logic          ack_o, stall_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]    sram_be_n;
  logic [AW-1:0] sram_addr_o;

  logic [31:0]   sram_mem [64];
  logic [31:0]   ref_mem  [64];
  logic [31:0]   last_rd;
  int unsigned   n_assert = 0;
  int unsigned   n_fail = 0;

  sram_ctrl #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .sel_i(sel_i),
    .data_i(data_i), .tlb_hit_i(tlb_hit_i), .sram_ce_i(sram_ce_i), .data_o(data_o),
    .ack_o(ack_o), .stall_o(stall_o), .sram_addr_o(sram_addr_o), .sram_dq_i(sram_dq_i),
    .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: drives data only while selected and output-enabled.
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr_o[5:0]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) sram_mem[sram_addr_o[5:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("oe_and_dq_oe_exclusive", {31'b0, sram_dq_oe & ~sram_oe_n}, 32'd0);
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wd, input logic hit, input logic ce);
    logic        acc;
    logic        got;
    int unsigned idx, exp_lat, exp_oe, exp_we, exp_dq, lat, oe_cnt, we_cnt, dq_cnt, budget;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    acc = hit & ce;
    idx = int'(addr[7:2]);
    exp_rd = ref_mem[idx];
`ifdef SRAM_BYTE_WRITE_EN
    exp_be = ~sel;
`else
    exp_be = 4'h0;
`endif
    exp_oe = 0; exp_we = 0; exp_dq = 0;
    if (!we) begin
      exp_lat = W + 1; exp_oe = W;
    end else if (sel == 4'h0) begin
      exp_lat = 1;
    end else if (sel == 4'hF) begin
      exp_lat = W + 2; exp_we = W; exp_dq = W + 1;
    end else begin
`ifdef SRAM_BYTE_WRITE_EN
      exp_lat = W + 2; exp_we = W; exp_dq = W + 1;
`else
      exp_lat = 2 * W + 2; exp_oe = W; exp_we = W; exp_dq = W + 1;
`endif
    end
    if (!acc) exp_lat = 0;
    budget = acc ? 40 : 6;

    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; data_i = wd;
    tlb_hit_i = hit; sram_ce_i = ce;
    #1;
    chk("stall_in_accept_cycle", {31'b0, stall_o}, {31'b0, acc});
    @(posedge clk);
    #1;
    req_i = 1'b0; data_i = $urandom; sel_i = 4'($urandom); we_i = 1'($urandom);

    got = 1'b0; lat = 0; oe_cnt = 0; we_cnt = 0; dq_cnt = 0;
    for (int n = 1; n <= int'(budget); n++) begin
      @(negedge clk);
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) begin
        we_cnt++;
        chk("be_n_during_write", {28'b0, sram_be_n}, {28'b0, exp_be});
      end
      if (sram_dq_oe) dq_cnt++;
      chk("stall_while_busy", {31'b0, stall_o}, {31'b0, (n < int'(exp_lat))});
      if (!acc) chk("no_strobe_when_ignored", {31'b0, sram_ce_n}, 32'd1);
      if (ack_o) begin
        got = 1'b1; lat = n;
        break;
      end
    end

    if (acc) begin
      chk("ack_latency", lat, exp_lat);
      chk("oe_low_cycles", oe_cnt, exp_oe);
      chk("we_low_cycles", we_cnt, exp_we);
      chk("dq_oe_cycles", dq_cnt, exp_dq);
      chk("sram_addr_at_ack", {12'b0, sram_addr_o}, {12'b0, addr[21:2]});
      chk("strobes_high_at_ack", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
      if (!we) begin
        chk("read_data", data_o, exp_rd);
        last_rd = exp_rd;
      end else begin
        chk("data_o_held_on_write", data_o, last_rd);
        for (int b = 0; b < 4; b++)
          if (sel[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end else begin
      chk("no_ack_when_ignored", {31'b0, got}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 64; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    last_rd = 32'h0;

    // Reset with a request pending: nothing may start.
    rst = 1'b1; req_i = 1'b1; tlb_hit_i = 1'b1; sram_ce_i = 1'b1; we_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
    chk("reset_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
    chk("reset_ack", {31'b0, ack_o}, 32'd0);
    chk("reset_stall", {31'b0, stall_o}, 32'd0);
    chk("reset_be_n", {28'b0, sram_be_n}, 32'hF);
    chk("reset_data_o", data_o, 32'h0);
    chk("reset_sram_addr", {12'b0, sram_addr_o}, 32'h0);
    req_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    sram_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    access(1'b0, 32'h0000_0010, 4'hF, 32'h0, 1'b1, 1'b1);
    access(1'b1, 32'h0000_0020, 4'hF, 32'h1234_5678, 1'b1, 1'b1);
    access(1'b1, 32'h0000_0020, 4'h1, 32'h0000_00AB, 1'b1, 1'b1);
    chk("partial_write_word", sram_mem[8], 32'h1234_56AB);
    access(1'b0, 32'h0000_0020, 4'hF, 32'h0, 1'b1, 1'b1);
    access(1'b0, 32'h0000_0030, 4'hF, 32'h0, 1'b0, 1'b1);
    access(1'b1, 32'h0000_0030, 4'hF, 32'h5555_5555, 1'b1, 1'b0);
    access(1'b1, 32'h0000_0030, 4'h0, 32'h6666_6666, 1'b1, 1'b1);

    // Reset in the first WR cycle: the access is abandoned without an ack.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0040; sel_i = 4'hF; data_i = 32'hCAFE_F00D;
    tlb_hit_i = 1'b1; sram_ce_i = 1'b1;
    @(posedge clk); #1 req_i = 1'b0;
    @(negedge clk);
    chk("abort_we_active", {31'b0, sram_we_n}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ref_mem[16] = 32'hCAFE_F00D;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("abort_we_n", {31'b0, sram_we_n}, 32'd1);
      chk("abort_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
      chk("abort_no_ack", {31'b0, ack_o}, 32'd0);
      chk("abort_no_stall", {31'b0, stall_o}, 32'd0);
    end
    last_rd = 32'h0;
    access(1'b0, 32'h0000_0040, 4'hF, 32'h0, 1'b1, 1'b1);

    for (int t = 0; t < 60; t++) begin
      logic [3:0] s;
      a = {10'($urandom), 14'd0, 6'($urandom), 2'($urandom)};
      case ($urandom_range(0, 3))
        0: s = 4'hF;
        1: s = 4'h0;
        default: s = 4'($urandom);
      endcase
      access(1'($urandom), a, s, $urandom, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0));
    end

    for (int i = 0; i < 64; i++) chk("final_memory", sram_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
